wide_add_sequencer: RTL

//  Multi-cycle adder controller: adds two WIDTH-bit operands by reusing one CHUNK-bit

---
 rtl/wide_add_pkg.sv | 29 ++
 rtl/wide_add_sequencer_cra_chunk.sv | 39 +++
 rtl/wide_add_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the wide_add_sequencer block:
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - nchunk    : number of chunk-adder passes for a WIDTH/CHUNK pair
//   - idx_width : width of the chunk index counter (at least 1 bit)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = nchunk(width, chunk);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_cra_chunk.sv
// -----------------------------------------------------------------------------
// cra_chunk
// Combinational CHUNK-bit ripple-carry adder, reused every cycle by
// wide_add_sequencer.
// Ports:
//   i_a, i_b  in  CHUNK  addend slices
//   i_cin     in  1      carry into bit 0
//   o_sum     out CHUNK  slice sum
//   o_cout    out 1      carry out of the top bit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cra_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Adds two WIDTH-bit operands over NCHUNK = WIDTH/CHUNK cycles using a single
// shared CHUNK-bit ripple-carry adder; the carry is registered between chunks.
// Valid/ready handshakes on both the operand and the result side.
//
// Optional feature macro: WIDE_ADD_SEQ_SUB_EN
//   adds in_sub (subtract a - b, in_cin ignored) and out_ovf (signed overflow).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin   operands and carry-in, sampled at acceptance
//   in_sub               (macro only) subtract select, sampled at acceptance
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   out_sum, out_cout    WIDTH-bit sum and final carry-out
//   out_ovf              (macro only) signed overflow of the full result
//   busy                 high in RUN or DONE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic             in_sub,
  output logic             out_ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(WIDTH, CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("wide_add_sequencer: CHUNK must be >= 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("wide_add_sequencer: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_last;

  // Subtraction is folded into the operand capture: a - b == a + ~b + 1.
`ifdef WIDE_ADD_SEQ_SUB_EN
  logic r_ovf;
  assign w_b_eff   = in_sub ? ~in_b : in_b;
  assign w_cin_eff = in_sub ? 1'b1  : in_cin;
  assign out_ovf   = r_ovf;
`else
  assign w_b_eff   = in_b;
  assign w_cin_eff = in_cin;
`endif

  assign w_last = (r_idx == LAST_IDX);

  cra_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (r_a[int'(r_idx) * CHUNK +: CHUNK]),
    .i_b    (r_b[int'(r_idx) * CHUNK +: CHUNK]),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef WIDE_ADD_SEQ_SUB_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_chunk_sum;
          r_carry <= w_chunk_cout;
          if (w_last) begin
            r_cout <= w_chunk_cout;
            r_idx  <= '0;
`ifdef WIDE_ADD_SEQ_SUB_EN
            // Overflow: both addends share a sign that the result's MSB lacks.
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                      (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

endmodule
